// File: rtl/bcd_seg_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment display.
package bcd_seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/bcd_seg_display_seg7_decode.sv
// Nibble to active-low {g,f,e,d,c,b,a} segment decoder; non-BCD nibbles show a dash.
module seg7_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_seg_display.sv
// Four-digit multiplexed BCD seven-segment driver with registered outputs.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_seg_display
  import bcd_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bcd_valid,
  input  logic [15:0]           bcd,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  bcd_err
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]   cap;
  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic          tick;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          blank;
  logic          err_c;

  assign tick   = (cnt == CW'(REFRESH_DIV - 1));
  assign nibble = cap[idx*4 +: 4];
  assign dp     = 1'b1;

  seg7_decode u_dec (.nibble(nibble), .seg(seg_dec));

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only when it and every higher digit are zero; ones never blanks.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (cap[15:4]  == 12'd0);
      2'd2:    blank = (cap[15:8]  == 8'd0);
      2'd3:    blank = (cap[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cap[i*4 +: 4] > 4'd9) err_c = 1'b1;
  end

  // Outputs derive from registered idx/cap, so a capture coinciding with a
  // tick lands together with the new digit select: no stale-digit glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap     <= '0;
      cnt     <= '0;
      idx     <= '0;
      seg     <= SEG_BLANK;
      an      <= '1;
      bcd_err <= 1'b0;
    end else begin
      if (bcd_valid) cap <= bcd;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg     <= blank ? SEG_BLANK : seg_dec;
      an      <= ~(NUM_DIGITS'(1) << idx);
      bcd_err <= err_c;
    end
  end
endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench: stimulus pushes the expected output of each edge, a negedge monitor pops and compares.
module tb_bcd_seg_display;
  import bcd_seg_pkg::*;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bcd_valid = 1'b0;
  logic [15:0] bcd = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        bcd_err;

  bcd_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bcd_valid(bcd_valid), .bcd(bcd),
    .seg(seg), .an(an), .dp(dp), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       err;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] cap_m = '0;
  int          n_edges = 0;
  logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Expected display for digit position idx of a captured value c.
  function automatic exp_t model(input int idx, input logic [15:0] c);
    exp_t e;
    int   nib;
    logic err;
    err = 1'b0;
    for (int i = 0; i < 4; i++)
      if (((c >> (4 * i)) & 16'hF) > 9) err = 1'b1;
    nib   = int'((c >> (4 * idx)) & 16'hF);
    e.seg = dec_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (c >> (4 * idx)) == 16'd0) e.seg = 7'h7F;
`endif
    e.an  = 4'hF & ~(4'b0001 << idx);
    e.dp  = 1'b1;
    e.err = err;
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    exp_t e;
    int   idx;
    reset = r; bcd_valid = v; bcd = d;
    if (r) begin
      e = '{seg: 7'h7F, an: 4'hF, dp: 1'b1, err: 1'b0};
      n_edges = 0;
      cap_m = '0;
    end else begin
      idx = (n_edges / DIV) % 4;
      e = model(idx, cap_m);
      n_edges++;
      if (v) cap_m = d;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      e_m = q.pop_front();
      checks++;
      if ({seg, an, dp, bcd_err} !== e_m) begin
        failures++;
        $display("FAIL outputs cyc=%0d got seg=%b an=%b dp=%b err=%b exp seg=%b an=%b dp=%b err=%b",
                 cyc, seg, an, dp, bcd_err, e_m.seg, e_m.an, e_m.dp, e_m.err);
      end
      if (e_m.an != 4'hF) begin
        checks++;
        if ($countones(~an) != 1) begin
          failures++;
          $display("FAIL an_onehot cyc=%0d got an=%b exp one low bit", cyc, an);
        end
      end
    end
  end

  initial begin
    // Reset, then first post-reset cycle shows "0" on digit 0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
    idle(3);
    // Full scan of 4095.
    step(1'b0, 1'b1, 16'h4095);
    idle(20);
    // Non-BCD nibble.
    step(1'b0, 1'b1, 16'h00A3);
    idle(18);
    // Leading-zero candidate.
    step(1'b0, 1'b1, 16'h0005);
    idle(18);
    // Capture on a tick edge.
    step(1'b0, 1'b1, 16'h9999);
    while ((n_edges % DIV) != DIV - 1) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0123);
    idle(10);
    // Reset in the middle of digit 2.
    while (((n_edges / DIV) % 4) != 2 || (n_edges % DIV) != 1) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    idle(18);
    // Randomized traffic with occasional resets and tick collisions.
    for (int i = 0; i < 600; i++)
      step(($urandom % 50) == 0, ($urandom % 6) == 0, 16'($urandom));
    reset = 1'b0; bcd_valid = 1'b0;
    @(negedge clk); #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
